// File: rtl/clk_gen_pkg.sv
// Shared types and elaboration helpers for the clock-enable generator:
// FSM state encoding, divisor legality check and lock-counter width.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    LOCKING,
    RUN
  } state_e;

  function automatic bit div_legal(input longint unsigned div, input int unsigned cnt_w);
    return (div != 0) && (div < (64'd1 << cnt_w));
  endfunction

  function automatic int unsigned lock_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

  localparam int unsigned LOCK_CYCLES_DEF = 16;
  localparam int unsigned LOCK_W_DEF      = lock_width(LOCK_CYCLES_DEF);

endpackage

// File: rtl/clk_div_chan.sv
// One divided-clock channel: modulo-DIV counter with registered ce and
// clk_out decoded from the next counter value.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int unsigned     CNT_W = 8,
  parameter longint unsigned DIV   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic ce,
  output logic clk_out
);

  if (!div_legal(DIV, CNT_W)) begin : g_bad_div
    $error("clk_div_chan: divisor %0d is illegal for CNT_W=%0d", DIV, CNT_W);
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_hi;

  always_comb begin
    cnt_d = '0;
    if (run && !clear && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // DIV=1 has no high phase; avoid a constant "< 0" compare.
  if (DIV >= 2) begin : g_hi
    assign clk_hi = (cnt_d < HALF);
  end else begin : g_lo
    assign clk_hi = 1'b0;
  end

  always_comb begin
    ce_d      = run && (cnt_d == LAST);
    clk_out_d = run && clk_hi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      ce_q      <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ce_q      <= ce_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign ce      = ce_q;
  assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: reset synchroniser, align/lock FSM
// and lock counter driving NUM_CH independent divider channels.
module clk_enable_gen
  import clk_gen_pkg::*;
#(
  parameter int unsigned               NUM_CH      = 2,
  parameter int unsigned               CNT_W       = 8,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_LIST    = {8'd4, 8'd2},
  parameter int unsigned               LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              en,
  input  logic              resync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] clk_out,
  output logic              LOCKED
);

  if ((NUM_CH < 1) || (NUM_CH > 8)) begin : g_bad_num_ch
    $error("clk_enable_gen: NUM_CH=%0d out of range 1..8", NUM_CH);
  end
  if ((LOCK_CYCLES < 1) || (LOCK_CYCLES > 65535)) begin : g_bad_lock
    $error("clk_enable_gen: LOCK_CYCLES=%0d out of range 1..65535", LOCK_CYCLES);
  end

  localparam int unsigned       LOCK_W   = lock_width(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);

  // Assertion is immediate through the async set; release takes two edges.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b0};
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      rst_sync_q <= '1;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int = rst_sync_q[1];

  state_e            state_q, state_d;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic              locked_q, locked_d;
  logic              chan_run;
  logic              chan_clr;

  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    chan_clr = 1'b0;
    case (state_q)
      IDLE: begin
        lock_d = '0;
        if (en) state_d = ALIGN;
      end
      ALIGN: begin
        lock_d   = '0;
        chan_clr = 1'b1;
        state_d  = LOCKING;
      end
      LOCKING: begin
        if (resync) begin
          lock_d   = '0;
          chan_clr = 1'b1;
        end else begin
          if (lock_q != LOCK_MAX) lock_d = lock_q + LOCK_W'(1);
          if (lock_d == LOCK_MAX) state_d = RUN;
        end
      end
      RUN: begin
        chan_clr = resync;
      end
      default: state_d = IDLE;
    endcase
    // Dropping en overrides everything, including a same-cycle resync.
    if (!en) begin
      state_d = IDLE;
      lock_d  = '0;
    end
    chan_run = (state_d == LOCKING) || (state_d == RUN);
    locked_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q  <= IDLE;
      lock_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      locked_q <= locked_d;
    end
  end

  assign LOCKED = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W (CNT_W),
      .DIV   (64'(DIV_LIST[i*CNT_W +: CNT_W]))
    ) u_chan (
      .clk     (clk),
      .rst     (rst_int),
      .run     (chan_run),
      .clear   (chan_clr),
      .ce      (ce[i]),
      .clk_out (clk_out[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: default divisors {4,2} and a second
// instance with divisors {5,1}, both driven by the same stimulus.
module tb_clk_enable_gen;

  logic       clk = 1'b0;
  logic       RESET;
  logic       en;
  logic       resync;
  logic [1:0] ce_a, clk_a, ce_b, clk_b;
  logic       lk_a, lk_b;
  logic [9:0] obs;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  clk_enable_gen #(
    .NUM_CH      (2),
    .CNT_W       (8),
    .DIV_LIST    ({8'd4, 8'd2}),
    .LOCK_CYCLES (16)
  ) dut_a (
    .clk     (clk),
    .RESET   (RESET),
    .en      (en),
    .resync  (resync),
    .ce      (ce_a),
    .clk_out (clk_a),
    .LOCKED  (lk_a)
  );

  clk_enable_gen #(
    .NUM_CH      (2),
    .CNT_W       (8),
    .DIV_LIST    ({8'd5, 8'd1}),
    .LOCK_CYCLES (16)
  ) dut_b (
    .clk     (clk),
    .RESET   (RESET),
    .en      (en),
    .resync  (resync),
    .ce      (ce_b),
    .clk_out (clk_b),
    .LOCKED  (lk_b)
  );

  assign obs = {ce_a, clk_a, lk_a, ce_b, clk_b, lk_b};

  // Expected outputs c cycles after the counters were last at 0.
  function automatic logic [9:0] exp_vec(input int c, input logic lk, input logic act);
    logic [1:0] cea, cka, ceb, ckb;
    cea = {(c % 4) == 3, (c % 2) == 1};
    cka = {(c % 4) < 2, (c % 2) == 0};
    ceb = {(c % 5) == 4, 1'b1};
    ckb = {(c % 5) < 2, 1'b0};
    if (!act) return '0;
    return {cea, cka, lk, ceb, ckb, lk};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en     = 1'b0;
    resync = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [9:0] e;
    RESET = 1'b0; en = 1'b0; resync = 1'b0;
    #2 RESET = 1'b1;
    step(); step();
    e = '0; checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold: got %b expected %b", obs, e); end
    en = 1'b1;
    step(); step();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold_en: got %b expected %b", obs, e); end
    RESET = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL reset_release n=%0d: got %b expected %b", n, obs, e); end
    end
    for (int c = 0; c < 24; c++) begin
      step();
      e = exp_vec(c, c >= 16, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL first_lock c=%0d: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_lock_sequence();
    logic [9:0] e;
    go_idle();
    e = '0; checks++;
    if (obs !== e) begin errors++; $display("FAIL idle: got %b expected %b", obs, e); end
    en = 1'b1;
    step();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL align: got %b expected %b", obs, e); end
    for (int c = 0; c < 24; c++) begin
      step();
      e = exp_vec(c, c >= 16, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL lock_seq c=%0d: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_resync_run();
    logic [9:0] e;
    for (int c = 24; c <= 26; c++) begin
      step();
      e = exp_vec(c, 1'b1, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL pre_resync c=%0d: got %b expected %b", c, obs, e); end
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    for (int j = 0; j <= 9; j++) begin
      if (j > 0) step();
      e = exp_vec(j, 1'b1, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL resync_run j=%0d: got %b expected %b", j, obs, e); end
    end
    // At j=9 ch0 is about to wrap; two resync cycles must hold everything at 0.
    resync = 1'b1;
    for (int n = 0; n < 2; n++) begin
      step();
      e = exp_vec(0, 1'b1, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL resync_wrap n=%0d: got %b expected %b", n, obs, e); end
    end
    resync = 1'b0;
    step();
    e = exp_vec(1, 1'b1, 1'b1); checks++;
    if (obs !== e) begin errors++; $display("FAIL resync_after_wrap: got %b expected %b", obs, e); end
  endtask

  task automatic test_resync_locking();
    logic [9:0] e;
    go_idle();
    en = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      e = exp_vec(c, 1'b0, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL locking_pre c=%0d: got %b expected %b", c, obs, e); end
    end
    resync = 1'b1;
    step();
    resync = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) step();
      e = exp_vec(j, j >= 16, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL resync_locking j=%0d: got %b expected %b", j, obs, e); end
    end
  endtask

  task automatic test_resync_ignored();
    logic [9:0] e;
    go_idle();
    resync = 1'b1;
    e = '0;
    step();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL resync_idle: got %b expected %b", obs, e); end
    en = 1'b1;
    step();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL resync_align: got %b expected %b", obs, e); end
    step();
    resync = 1'b0;
    for (int c = 0; c < 18; c++) begin
      if (c > 0) step();
      e = exp_vec(c, c >= 16, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL resync_ignored c=%0d: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] e;
    checks++;
    if (lk_a !== 1'b1) begin errors++; $display("FAIL pre_reset_locked: got %b expected 1", lk_a); end
    @(posedge clk);
    #3 RESET = 1'b1;
    #1;
    e = '0; checks++;
    if (obs !== e) begin errors++; $display("FAIL async_reset: got %b expected %b", obs, e); end
    step(); step();
    RESET = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL rerelease n=%0d: got %b expected %b", n, obs, e); end
    end
    for (int c = 0; c < 18; c++) begin
      step();
      e = exp_vec(c, c >= 16, 1'b1); checks++;
      if (obs !== e) begin errors++; $display("FAIL relock c=%0d: got %b expected %b", c, obs, e); end
    end
  endtask

  task automatic test_en_drop();
    logic [9:0] e;
    // Now at c=17: ch0 at DIV-1, so a wrap coincides with resync and en=0.
    en     = 1'b0;
    resync = 1'b1;
    step();
    resync = 1'b0;
    e = '0; checks++;
    if (obs !== e) begin errors++; $display("FAIL en_drop: got %b expected %b", obs, e); end
    step();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL en_drop_idle: got %b expected %b", obs, e); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_resync_run();
    test_resync_locking();
    test_resync_ignored();
    test_async_reset();
    test_en_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, meaning the number of independent divided-clock channels (legal range 1..8).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of each channel's divide counter.
REQ-003 The block SHALL have parameter DIV_LIST, default {8'd4, 8'd2}, meaning packed NUM_CH*CNT_W divisors, with channel 0 in the least-significant CNT_W bits.
REQ-004 The block SHALL have parameter LOCK_CYCLES, default 16, meaning the number of running cycles before LOCKED asserts (legal range 1..65535).
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-007 The block SHALL have port en, input, 1 bit: run enable, level-sensitive.
REQ-008 The block SHALL have port resync, input, 1 bit: a single-cycle request to realign all channels.
REQ-009 The block SHALL have port ce, output, NUM_CH bits: one-cycle clock-enable pulse per channel.
REQ-010 The block SHALL have port clk_out, output, NUM_CH bits: registered fabric divided clock per channel, intended for pins and low-speed logic only.
REQ-011 The block SHALL have port LOCKED, output, 1 bit: outputs are stable and aligned.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, ALIGN, LOCKING and RUN.
REQ-013 The FSM transitions SHALL be as follows:
- IDLE to ALIGN when en=1.
- ALIGN to LOCKING after exactly one cycle.
- LOCKING to RUN when the lock counter reaches LOCK_CYCLES.
- Any state to IDLE when en=0, taking effect on the next edge.
REQ-014 In IDLE and ALIGN, all channel counters SHALL be 0, and ce, clk_out and LOCKED SHALL all be 0.
REQ-015 In LOCKING and RUN, each channel counter SHALL count 0..DIV-1 and wrap to 0, with the first counting cycle at count 0.
REQ-016 ce[i] SHALL be high exactly in the cycles where counter i equals DIV_i-1, giving one pulse per DIV_i cycles.
REQ-017 clk_out[i] SHALL be high while counter i < DIV_i/2 (integer division) and low otherwise, so even divisors give 50% duty and odd divisors give floor(DIV/2)/DIV.
REQ-018 DIV_i=1 SHALL produce ce[i] constantly high while counting, with clk_out[i] held at 0.
REQ-019 DIV_i=0 or DIV_i >= 2^CNT_W SHALL be an elaboration-time error.
REQ-020 ce and clk_out SHALL be flop outputs decoded from the next-state counter value, so they are glitch-free and have zero cycles of lag relative to the counter.
REQ-021 The lock counter SHALL increment once per LOCKING cycle and saturate, with width clog2(LOCK_CYCLES+1).
REQ-022 LOCKED SHALL go to 1 in the first RUN cycle and remain 1 until en=0 or RESET.
REQ-023 resync=1 in LOCKING or RUN SHALL clear all channel counters to 0 on the next edge, with every channel aligned simultaneously.
REQ-024 resync=1 in LOCKING SHALL additionally restart the lock counter from 0.
REQ-025 resync=1 in RUN SHALL leave LOCKED high.
REQ-026 resync SHALL be ignored in IDLE and ALIGN.
REQ-027 When resync and a counter wrap occur in the same cycle, resync SHALL win: the counter goes to 0, with no double pulse and no skipped pulse beyond that realignment.
REQ-028 When en falls and resync rises in the same cycle, en SHALL win and the FSM SHALL enter IDLE.
REQ-029 Channels SHALL be independent, and ce pulses of channels whose divisors are common multiples SHALL coincide after every alignment.

Reset
REQ-030 RESET=1 SHALL asynchronously force state IDLE, all counters to 0, and ce, clk_out and LOCKED to 0.
REQ-031 RESET deassertion SHALL be synchronised internally with a 2-flop release so that the first active edge is clean.
REQ-032 RESET asserted mid-operation (LOCKING or RUN) SHALL drop LOCKED immediately, without waiting for a clock edge.
REQ-033 After RESET release with en=1, the block SHALL pass through ALIGN and then the full LOCKING period again.

Structure
REQ-034 Package clk_gen_pkg SHALL hold the FSM state enum, the divisor legality check function and the clog2-based lock-width constant.
REQ-035 Sub-module clk_div_chan SHALL implement one channel (counter, ce decode, clk_out decode, clear input) and SHALL be instantiated NUM_CH times by a generate loop.
REQ-036 The top level SHALL hold only the FSM, the lock counter and the reset synchroniser.
REQ-037 The block SHALL contain no clocking primitives or BUFGs, and SHALL be pure fabric logic.

Verification
REQ-038 Default parameters, RESET released, en=1 held: ALIGN lasts 1 cycle; then ce[0] pulses every 2 cycles and ce[1] every 4 cycles, coincident on every 4th cycle; LOCKED rises after 16 LOCKING cycles.
REQ-039 DIV_LIST={8'd5, 8'd1}: ce[0] stays high continuously with clk_out[0]=0; clk_out[1] has pattern 1,1,0,0,0 repeating; ce[1] is high on the 5th cycle of each period.
REQ-040 resync pulsed in RUN at ch1 count 2: next cycle both counters are 0; LOCKED stays 1; the next ce[1] comes 4 cycles later.
REQ-041 resync pulsed at LOCKING cycle 10: the lock counter restarts, and LOCKED rises 16 cycles after the resync instead of 6.
REQ-042 RESET asserted asynchronously mid-RUN between edges: LOCKED, ce and clk_out are 0 before the next edge; after release, the ALIGN plus 16-cycle lock sequence repeats.
REQ-043 en dropped coincident with resync and with a ch0 wrap: the next state is IDLE, all outputs are 0 next cycle, and no ce pulse is emitted in that cycle.
